mem_store_unit: RTL and testbench
=================================

# mem_store_unit

Parametrised sequential store unit between the core's memory stage and the data-memory bus. Accepts one store request (SB/SH/SW/SD) per handshake, steers data into byte lanes, and issues one bus beat, or two when a misaligned access crosses a bus word. Alignment and illegal-width stores raise an exception instead of writing. Generalises the combinational store controller to XLEN 32/64, adds a valid/ready bus protocol with backpressure, and adds optional misaligned-access splitting.

## Interface
- XLEN, 32: data/address width, 32 or 64; bus width equals XLEN; BUS_BYTES = XLEN/8.
- SPLIT_MISALIGNED, 1: 1 = execute misaligned stores in one or two beats; 0 = misaligned stores raise an exception.
- iCLK  in  1  clock, rising edge.
- iRST_n  in  1  reset; one clock, asynchronous assert, active-low.
- iReqValid  in  1  store request valid.
- oReqReady  out  1  unit can accept a request.
- iAddr  in  XLEN  byte address.
- iFunct3  in  3  000 SB, 001 SH, 010 SW, 011 SD; all others illegal.
- iData  in  XLEN  store data, right-justified.
- oBusValid  out  1  bus beat valid.
- iBusReady  in  1  bus accepts the beat.
- oBusAddr  out  XLEN  beat address, aligned to BUS_BYTES (low log2(BUS_BYTES) bits are 0).
- oBusData  out  XLEN  lane-steered data; disabled lanes are 0.
- oBusByteEnable  out  BUS_BYTES  lane enables, bit i = byte lane i.
- oDone  out  1  one-cycle pulse: request retired.
- oException  out  1  qualified by oDone: request retired without writing.
- oExcCode  out  2  valid with oException: 01 misaligned, 10 illegal funct3; 00 otherwise.

## Operation
- States: IDLE, BEAT0, BEAT1.
- oReqReady = (state == IDLE). A request is accepted on the rising edge with iReqValid && oReqReady; all request fields are registered then.
- size = 1 << iFunct3[1:0]; off = iAddr mod BUS_BYTES.
- Illegal: iFunct3[2] = 1, or iFunct3 = 011 with XLEN = 32 → code 10.
- Misaligned: off mod size ≠ 0. With SPLIT_MISALIGNED = 0 → code 01.
- On exception: state stays IDLE; the next cycle pulses oDone = oException = 1 with the code. No bus beat is issued.
- Otherwise, build a 2·BUS_BYTES mask = ((1<<size)−1) << off and 2·XLEN data = iData[size·8−1:0] << (off·8), little-endian.
- BEAT0 drives addr = iAddr with the low bits cleared, the lower half of mask/data.
- BEAT1 is entered only if the upper-half mask ≠ 0. It drives addr = BEAT0 addr + BUS_BYTES (wraps modulo 2^XLEN) and the upper half of mask/data.
- BEAT0 handshake → BEAT1 if needed, else IDLE. BEAT1 handshake → IDLE. The final handshake pulses oDone (oException = 0) in the next cycle.
- With SPLIT_MISALIGNED = 1, misaligned accesses that stay within one bus word use a single beat.

## Timing
- Reset values: state IDLE; oReqReady 1 (after reset release); oBusValid 0; oBusAddr, oBusData, oBusByteEnable 0; oDone 0; oException 0; oExcCode 00.
- Latency: accept at edge N → oBusValid high from cycle N+1. With iBusReady = 1, the single-beat oDone pulse is at N+2 and the two-beat pulse at N+3.
- oBusValid, once high, stays high and oBusAddr/oBusData/oBusByteEnable stay stable until iBusReady is sampled high. iBusReady is ignored while oBusValid = 0.
- All outputs are registered; there is no combinational iBusReady→oBusValid path.
- Back-to-back: the oDone pulse coincides with IDLE and oReqReady = 1, so a new request can be accepted in the same cycle the previous one's oDone shows. The exception path sustains one request per cycle.
- Reset mid-transaction clears outputs immediately. A pending beat is dropped; if BEAT0 completed, the partially written BEAT0 data is not undone, and no oDone is issued.

## Test plan
- XLEN 32: SW addr 0x100, data 0xDEADBEEF, iBusReady = 1 → one beat: addr 0x100, BE 1111, data 0xDEADBEEF; oDone 2 cycles after accept, oException 0.
- SB addr 0x103, data 0x000000A5 → addr 0x100, BE 1000, data 0xA5000000. SH addr 0x201, data 0x0000BBAA, SPLIT = 1 → single beat: addr 0x200, BE 0110, data 0x00BBAA00.
- SW addr 0x102, data 0x11223344, SPLIT = 1 → beat0: addr 0x100, BE 1100, data 0x33440000. beat1: addr 0x104, BE 0011, data 0x00001122. One oDone.
- Same request with SPLIT = 0 → oBusValid never rises; oDone = oException = 1, oExcCode 01 the next cycle. funct3 011 on XLEN 32 → oExcCode 10. funct3 100 → oExcCode 10.
- Backpressure: hold iBusReady = 0 for 3 cycles during beat0 of a split store → beat0 fields stable throughout; beat1 follows the handshake; oReqReady stays 0 until retirement.
- Drop iRST_n mid-BEAT1 → oBusValid 0 immediately, no oDone. After release a new SW addr 0x0 completes normally. XLEN 64 SD addr 0x7FC → beats at 0x7F8 (BE 0xF0) and 0x800 (BE 0x0F).

Source files
------------

// File: rtl/mem_store_unit.sv
// Sequential store unit: steers SB/SH/SW/SD data into bus byte lanes and issues
// one or two valid/ready bus beats, or retires the request with an exception.
module mem_store_unit #(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic [XLEN-1:0]   iAddr,
    input  logic [2:0]        iFunct3,
    input  logic [XLEN-1:0]   iData,
    output logic              oBusValid,
    input  logic              iBusReady,
    output logic [XLEN-1:0]   oBusAddr,
    output logic [XLEN-1:0]   oBusData,
    output logic [XLEN/8-1:0] oBusByteEnable,
    output logic              oDone,
    output logic              oException,
    output logic [1:0]        oExcCode
);
    localparam int BB = XLEN / 8;
    localparam int OW = $clog2(BB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
    state_t state;

    logic [BB-1:0]     hi_be;
    logic [XLEN-1:0]   hi_data;

    logic [3:0]        size;
    logic [OW-1:0]     off;
    logic              illegal;
    logic              misaligned;
    logic [BB-1:0]     smask;
    logic [XLEN-1:0]   dmask;
    logic [2*BB-1:0]   wmask;
    logic [2*XLEN-1:0] wdata;

    // Double-width mask/data: the upper half spills into the next bus word.
    always_comb begin
        size       = 4'd1 << iFunct3[1:0];
        off        = iAddr[OW-1:0];
        illegal    = iFunct3[2] || (iFunct3[1:0] == 2'b11 && XLEN == 32);
        misaligned = (off & OW'(size - 4'd1)) != '0;
        smask      = (BB'(1) << size) - BB'(1);
        dmask      = '0;
        for (int i = 0; i < BB; i++)
            dmask[i*8 +: 8] = {8{smask[i]}};
        wmask      = {{BB{1'b0}}, smask} << off;
        wdata      = {{XLEN{1'b0}}, iData & dmask} << {off, 3'b000};
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state          <= IDLE;
            oReqReady      <= 1'b1;
            oBusValid      <= 1'b0;
            oBusAddr       <= '0;
            oBusData       <= '0;
            oBusByteEnable <= '0;
            oDone          <= 1'b0;
            oException     <= 1'b0;
            oExcCode       <= 2'b00;
            hi_be          <= '0;
            hi_data        <= '0;
        end else begin
            oDone      <= 1'b0;
            oException <= 1'b0;
            oExcCode   <= 2'b00;
            case (state)
                IDLE: if (iReqValid) begin
                    if (illegal) begin
                        oDone      <= 1'b1;
                        oException <= 1'b1;
                        oExcCode   <= 2'b10;
                    end else if (misaligned && !SPLIT_MISALIGNED) begin
                        oDone      <= 1'b1;
                        oException <= 1'b1;
                        oExcCode   <= 2'b01;
                    end else begin
                        state          <= BEAT0;
                        oReqReady      <= 1'b0;
                        oBusValid      <= 1'b1;
                        oBusAddr       <= {iAddr[XLEN-1:OW], {OW{1'b0}}};
                        oBusData       <= wdata[XLEN-1:0];
                        oBusByteEnable <= wmask[BB-1:0];
                        hi_data        <= wdata[2*XLEN-1:XLEN];
                        hi_be          <= wmask[2*BB-1:BB];
                    end
                end
                BEAT0: if (iBusReady) begin
                    if (hi_be != '0) begin
                        state          <= BEAT1;
                        oBusAddr       <= oBusAddr + XLEN'(BB);
                        oBusData       <= hi_data;
                        oBusByteEnable <= hi_be;
                    end else begin
                        state          <= IDLE;
                        oReqReady      <= 1'b1;
                        oBusValid      <= 1'b0;
                        oBusAddr       <= '0;
                        oBusData       <= '0;
                        oBusByteEnable <= '0;
                        oDone          <= 1'b1;
                    end
                end
                BEAT1: if (iBusReady) begin
                    state          <= IDLE;
                    oReqReady      <= 1'b1;
                    oBusValid      <= 1'b0;
                    oBusAddr       <= '0;
                    oBusData       <= '0;
                    oBusByteEnable <= '0;
                    oDone          <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: three instances (32/split, 32/no-split, 64/split)
// driven by directed and random stores, checked against a byte-level model.
module tb_mem_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv[3];
    logic [63:0] addr_i = '0;
    logic [2:0]  f3_i = '0;
    logic [63:0] data_i = '0;
    logic        bus_ready = 1'b0;

    logic        rr[3], bv[3], dn[3], ex[3];
    logic [1:0]  cd[3];
    logic [63:0] ba[3], bd[3];
    logic [7:0]  be[3];
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  e0, e1;
    logic [63:0] a2, d2;
    logic [7:0]  e2;

    assign ba[0] = {32'h0, a0}; assign bd[0] = {32'h0, d0}; assign be[0] = {4'h0, e0};
    assign ba[1] = {32'h0, a1}; assign bd[1] = {32'h0, d1}; assign be[1] = {4'h0, e1};
    assign ba[2] = a2;          assign bd[2] = d2;          assign be[2] = e2;

    always #5 clk = ~clk;

    mem_store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u0 (
        .iCLK(clk), .iRST_n(rst_n), .iReqValid(rv[0]), .oReqReady(rr[0]),
        .iAddr(addr_i[31:0]), .iFunct3(f3_i), .iData(data_i[31:0]),
        .oBusValid(bv[0]), .iBusReady(bus_ready), .oBusAddr(a0), .oBusData(d0),
        .oBusByteEnable(e0), .oDone(dn[0]), .oException(ex[0]), .oExcCode(cd[0]));
    mem_store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) u1 (
        .iCLK(clk), .iRST_n(rst_n), .iReqValid(rv[1]), .oReqReady(rr[1]),
        .iAddr(addr_i[31:0]), .iFunct3(f3_i), .iData(data_i[31:0]),
        .oBusValid(bv[1]), .iBusReady(bus_ready), .oBusAddr(a1), .oBusData(d1),
        .oBusByteEnable(e1), .oDone(dn[1]), .oException(ex[1]), .oExcCode(cd[1]));
    mem_store_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u2 (
        .iCLK(clk), .iRST_n(rst_n), .iReqValid(rv[2]), .oReqReady(rr[2]),
        .iAddr(addr_i), .iFunct3(f3_i), .iData(data_i),
        .oBusValid(bv[2]), .iBusReady(bus_ready), .oBusAddr(a2), .oBusData(d2),
        .oBusByteEnable(e2), .oDone(dn[2]), .oException(ex[2]), .oExcCode(cd[2]));

    int tests = 0;
    int fails = 0;

    int          m_code, m_nb;
    logic [63:0] m_a[2], m_d[2];
    logic [7:0]  m_be[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: place each stored byte individually by its own address.
    function automatic void model(input int k, input logic [63:0] addr,
                                  input logic [2:0] f3, input logic [63:0] data);
        int xl, bb, size, beat, lane;
        bit split;
        logic [63:0] msk, base, a;
        xl    = (k == 2) ? 64 : 32;
        split = (k != 1);
        bb    = xl / 8;
        msk   = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        size  = 1 << f3[1:0];
        m_code = 0; m_nb = 0;
        for (int i = 0; i < 2; i++) begin m_a[i] = '0; m_d[i] = '0; m_be[i] = '0; end
        if (f3[2] || (f3[1:0] == 2'b11 && xl == 32)) m_code = 2;
        else if (((addr % 64'(bb)) % 64'(size)) != 0 && !split) m_code = 1;
        else begin
            base   = ((addr & msk) / 64'(bb)) * 64'(bb);
            m_a[0] = base;
            m_a[1] = (base + 64'(bb)) & msk;
            m_nb   = 1;
            for (int b = 0; b < size; b++) begin
                a    = (addr + 64'(b)) & msk;
                beat = ((a / 64'(bb)) * 64'(bb) == base) ? 0 : 1;
                lane = int'(a % 64'(bb));
                m_be[beat][lane] = 1'b1;
                m_d[beat][lane*8 +: 8] = data[b*8 +: 8];
                if (beat == 1) m_nb = 2;
            end
        end
    endfunction

    task automatic do_req(input int k, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] data, input int stall);
        model(k, addr, f3, data);
        addr_i = addr; f3_i = f3; data_i = data;
        chk("ready_before", 64'(rr[k]), 64'd1);
        rv[k] = 1'b1;
        @(posedge clk); #1;
        rv[k] = 1'b0;
        if (m_code != 0) begin
            chk("exc_done", 64'(dn[k]), 64'd1);
            chk("exc_flag", 64'(ex[k]), 64'd1);
            chk("exc_code", 64'(cd[k]), 64'(m_code));
            chk("exc_novalid", 64'(bv[k]), 64'd0);
            chk("exc_ready", 64'(rr[k]), 64'd1);
        end else begin
            for (int b = 0; b < m_nb; b++) begin
                bus_ready = 1'b0;
                for (int s = 0; s <= ((b == 0) ? stall : 0); s++) begin
                    if (s > 0) begin @(posedge clk); #1; end
                    chk("beat_valid", 64'(bv[k]), 64'd1);
                    chk("beat_addr", ba[k], m_a[b]);
                    chk("beat_be", 64'(be[k]), 64'(m_be[b]));
                    chk("beat_data", bd[k], m_d[b]);
                    chk("busy_ready", 64'(rr[k]), 64'd0);
                    chk("busy_done", 64'(dn[k]), 64'd0);
                end
                bus_ready = 1'b1;
                @(posedge clk); #1;
                bus_ready = 1'b0;
            end
            chk("done", 64'(dn[k]), 64'd1);
            chk("done_exc", 64'(ex[k]), 64'd0);
            chk("done_code", 64'(cd[k]), 64'd0);
            chk("done_novalid", 64'(bv[k]), 64'd0);
            chk("done_ready", 64'(rr[k]), 64'd1);
        end
        @(posedge clk); #1;
        chk("done_pulse_end", 64'(dn[k]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] ad, dt;
        logic [2:0]  f;
        int k;
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 64'(bv[i]), 64'd0);
            chk("rst_addr", ba[i], 64'd0);
            chk("rst_data", bd[i], 64'd0);
            chk("rst_be", 64'(be[i]), 64'd0);
            chk("rst_done", 64'(dn[i]), 64'd0);
            chk("rst_exc", 64'(ex[i]), 64'd0);
            chk("rst_code", 64'(cd[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(0, 64'h100, 3'b010, 64'hDEADBEEF, 0);
        do_req(0, 64'h103, 3'b000, 64'h000000A5, 0);
        do_req(0, 64'h201, 3'b001, 64'h0000BBAA, 0);
        do_req(0, 64'h102, 3'b010, 64'h11223344, 0);
        do_req(1, 64'h102, 3'b010, 64'h11223344, 0);
        do_req(1, 64'h100, 3'b011, 64'h11223344, 0);
        do_req(0, 64'h100, 3'b100, 64'h11223344, 0);
        do_req(0, 64'h102, 3'b010, 64'h11223344, 3);
        do_req(2, 64'h7FC, 3'b011, 64'h0123456789ABCDEF, 0);
        do_req(0, 64'hFFFF_FFFE, 3'b010, 64'hCAFEF00D, 1);

        // Exception path retires one request per cycle.
        addr_i = 64'h101; f3_i = 3'b001; rv[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_done", 64'(dn[1]), 64'd1);
            chk("b2b_code", 64'(cd[1]), 64'd1);
            chk("b2b_ready", 64'(rr[1]), 64'd1);
        end
        rv[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end", 64'(dn[1]), 64'd0);

        // Reset during the second beat drops it and produces no retirement.
        addr_i = 64'h102; f3_i = 3'b010; data_i = 64'h11223344; rv[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0; bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        chk("rstmid_beat1_valid", 64'(bv[0]), 64'd1);
        chk("rstmid_beat1_addr", ba[0], 64'h104);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 64'(bv[0]), 64'd0);
        chk("rstmid_be", 64'(be[0]), 64'd0);
        chk("rstmid_done", 64'(dn[0]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstmid_nodone", 64'(dn[0]), 64'd0);
            chk("rstmid_ready", 64'(rr[0]), 64'd1);
        end
        do_req(0, 64'h0, 3'b010, 64'h5A5A1234, 0);

        for (int it = 0; it < 80; it++) begin
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                ad = (k == 2) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15)))
                              : (64'hFFFF_FFFF - 64'($urandom_range(0, 7)));
            else
                ad = (k == 2) ? {32'h0, $urandom} : {32'h0, $urandom & 32'h0000_0FFF};
            f  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            dt = {$urandom, $urandom};
            do_req(k, ad, f, dt, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
